cp0_exc_ctrl: RTL and testbench

- Sequencer and arbiter in front of the single CP0 register-file write port (wen/waddr/wdata).
- Serialises three requesters onto that port: pipeline exceptions, the timer interrupt, and MTC0 writes.
- For exceptions and interrupts it runs a multi-cycle write sequence (EPC, Cause, optionally BadVAddr), then issues a pipeline flush and redirect to the exception vector.
- Sits between the MEM-stage exception logic and CP0.

---
 rtl/cp0_exc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Sequencer/arbiter for the single CP0 write port: exceptions, timer interrupt and MTC0.
// Optional macro CP0_EXL_EN adds the exl input (nested-exception EPC preservation, interrupt gating).
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR       = 32'hBFC0_0380,
  parameter logic [4:0]  CP0_EPC_ADDR     = 5'd14,
  parameter logic [4:0]  CP0_CAUSE_ADDR   = 5'd13,
  parameter logic [4:0]  CP0_BADV_ADDR    = 5'd8,
  parameter logic [4:0]  CP0_COMPARE_ADDR = 5'd11
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef CP0_EXL_EN
  input  logic        exl,
`endif
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badva,
  output logic        exc_ack,
  input  logic [31:0] int_pc,
  input  logic        timer_int,
  input  logic        mtc0_req,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        mtc0_ack,
  output logic        cp0_wen,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  // Handshake: a request is accepted in the cycle its ack is 1; requesters hold
  // req and payload stable until then, and may drop or replace them on the next edge.
  typedef enum logic [2:0] {
    S_IDLE, S_MTC0, S_W_EPC, S_W_CAUSE, S_W_BADV, S_REDIRECT
  } state_t;

  state_t      state;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] badva_q;
  logic        tint_q;
  logic        int_mask;
  logic        exl_blk;
  logic        idle;
  logic        int_take;

`ifdef CP0_EXL_EN
  assign exl_blk = exl;
`else
  assign exl_blk = 1'b0;
`endif

  assign idle     = (state == S_IDLE);
  assign int_take = timer_int & ~int_mask & ~exl_blk;
  assign exc_ack  = idle & exc_req;
  assign mtc0_ack = idle & mtc0_req & ~exc_req & ~int_take;
  assign busy     = ~idle;

  function automatic logic [31:0] cause_word(input logic bd, input logic tint,
                                             input logic [4:0] code);
    logic [31:0] w;
    w       = '0;
    w[31]   = bd;
    w[15]   = tint;
    w[6:2]  = code;
    return w;
  endfunction

  function automatic logic [31:0] epc_word(input logic bd, input logic [31:0] pc);
    return bd ? pc - 32'd4 : pc;
  endfunction

  function automatic logic needs_badv(input logic [4:0] code);
    return (code == 5'd4) || (code == 5'd5);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      code_q      <= '0;
      pc_q        <= '0;
      bd_q        <= 1'b0;
      badva_q     <= '0;
      tint_q      <= 1'b0;
      int_mask    <= 1'b0;
      cp0_wen     <= 1'b0;
      cp0_waddr   <= '0;
      cp0_wdata   <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      cp0_wen     <= 1'b0;
      cp0_waddr   <= '0;
      cp0_wdata   <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      case (state)
        S_IDLE: begin
          if (exc_req) begin
            code_q  <= exc_code;
            pc_q    <= exc_pc;
            bd_q    <= exc_bd;
            badva_q <= exc_badva;
            tint_q  <= timer_int;
            cp0_wen <= 1'b1;
            if (exl_blk) begin
              // Nested exception: EPC keeps the outer handler's return address.
              state     <= S_W_CAUSE;
              cp0_waddr <= CP0_CAUSE_ADDR;
              cp0_wdata <= cause_word(exc_bd, timer_int, exc_code);
            end else begin
              state     <= S_W_EPC;
              cp0_waddr <= CP0_EPC_ADDR;
              cp0_wdata <= epc_word(exc_bd, exc_pc);
            end
          end else if (int_take) begin
            code_q    <= 5'd0;
            pc_q      <= int_pc;
            bd_q      <= 1'b0;
            badva_q   <= '0;
            tint_q    <= 1'b1;
            int_mask  <= 1'b1;
            state     <= S_W_EPC;
            cp0_wen   <= 1'b1;
            cp0_waddr <= CP0_EPC_ADDR;
            cp0_wdata <= int_pc;
          end else if (mtc0_req) begin
            state     <= S_MTC0;
            cp0_wen   <= 1'b1;
            cp0_waddr <= mtc0_addr;
            cp0_wdata <= mtc0_data;
          end
        end
        S_MTC0: begin
          // Writing Compare acknowledges the timer, so the interrupt may be taken again.
          if (cp0_waddr == CP0_COMPARE_ADDR) int_mask <= 1'b0;
          state <= S_IDLE;
        end
        S_W_EPC: begin
          state     <= S_W_CAUSE;
          cp0_wen   <= 1'b1;
          cp0_waddr <= CP0_CAUSE_ADDR;
          cp0_wdata <= cause_word(bd_q, tint_q, code_q);
        end
        S_W_CAUSE: begin
          if (needs_badv(code_q)) begin
            state     <= S_W_BADV;
            cp0_wen   <= 1'b1;
            cp0_waddr <= CP0_BADV_ADDR;
            cp0_wdata <= badva_q;
          end else begin
            state       <= S_REDIRECT;
            flush       <= 1'b1;
            redirect_pc <= EXC_VECTOR;
          end
        end
        S_W_BADV: begin
          state       <= S_REDIRECT;
          flush       <= 1'b1;
          redirect_pc <= EXC_VECTOR;
        end
        S_REDIRECT: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboarded bench for cp0_exc_ctrl: a cycle-count reference model predicts acks,
// busy and every CP0 port event; a monitor pops and compares port events.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_req = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badva = '0;
  logic        exc_ack;
  logic [31:0] int_pc = '0;
  logic        timer_int = 1'b0;
  logic        mtc0_req = 1'b0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic        mtc0_ack;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        busy;

  cp0_exc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva(exc_badva), .exc_ack(exc_ack),
    .int_pc(int_pc), .timer_int(timer_int),
    .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mtc0_ack(mtc0_ack),
    .cp0_wen(cp0_wen), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .flush(flush), .redirect_pc(redirect_pc), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  // Event word: {cycle[31:0], {wen,flush}[1:0], addr[4:0], data[31:0]}
  logic [70:0] exp_q[$];
  logic [70:0] mon_got;
  int tests = 0;
  int fails = 0;
  int free_at = 0;
  bit mask = 1'b0;
  bit exc_taken = 1'b0;
  bit mtc0_taken = 1'b0;

  task automatic check(input string name, input logic [70:0] got, input logic [70:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [70:0] ev(input int c, input logic [1:0] k,
                                     input logic [4:0] a, input logic [31:0] d);
    return {32'(c), k, a, d};
  endfunction

  // Exception/interrupt accepted in cycle n: EPC, Cause, optional BadVAddr, then flush.
  task automatic push_seq(input int n, input logic [4:0] code, input logic [31:0] pc,
                          input logic bd, input logic [31:0] badva, input logic tint);
    int t;
    logic [31:0] cause;
    t = n + 1;
    cause = '0;
    cause[31] = bd;
    cause[15] = tint;
    cause[6:2] = code;
    exp_q.push_back(ev(t, 2'b10, 5'd14, bd ? pc - 32'd4 : pc));
    t++;
    exp_q.push_back(ev(t, 2'b10, 5'd13, cause));
    t++;
    if (code == 5'd4 || code == 5'd5) begin
      exp_q.push_back(ev(t, 2'b10, 5'd8, badva));
      t++;
    end
    exp_q.push_back(ev(t, 2'b01, 5'd0, VEC));
    free_at = t + 1;
  endtask

  // ---------------- driver: one cycle of model + ack checks ----------------
  task automatic tick();
    bit e_ack;
    bit m_ack;
    bit busy_exp;
    @(negedge clk);
    e_ack = 1'b0;
    m_ack = 1'b0;
    exc_taken = 1'b0;
    mtc0_taken = 1'b0;
    busy_exp = (cyc < free_at);
    if (cyc >= free_at) begin
      if (exc_req) begin
        e_ack = 1'b1;
        exc_taken = 1'b1;
        push_seq(cyc, exc_code, exc_pc, exc_bd, exc_badva, timer_int);
      end else if (timer_int && !mask) begin
        mask = 1'b1;
        push_seq(cyc, 5'd0, int_pc, 1'b0, 32'd0, 1'b1);
      end else if (mtc0_req) begin
        m_ack = 1'b1;
        mtc0_taken = 1'b1;
        exp_q.push_back(ev(cyc + 1, 2'b10, mtc0_addr, mtc0_data));
        free_at = cyc + 2;
        if (mtc0_addr == 5'd11) mask = 1'b0;
      end
    end
    check("exc_ack", 71'(exc_ack), 71'(e_ack));
    check("mtc0_ack", 71'(mtc0_ack), 71'(m_ack));
    check("busy", 71'(busy), 71'(busy_exp));
    @(posedge clk);
    #1;
    if (exc_taken) exc_req = 1'b0;
    if (mtc0_taken) mtc0_req = 1'b0;
  endtask

  task automatic run_until_idle(input int lim);
    int n;
    n = 0;
    while ((exc_req || mtc0_req || cyc < free_at) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: actual still busy after %0d cycles, required idle", lim);
      exc_req = 1'b0;
      mtc0_req = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_wen"}, 71'(cp0_wen), 71'(0));
    check({name, "_waddr"}, 71'(cp0_waddr), 71'(0));
    check({name, "_wdata"}, 71'(cp0_wdata), 71'(0));
    check({name, "_flush"}, 71'(flush), 71'(0));
    check({name, "_redirect_pc"}, 71'(redirect_pc), 71'(0));
    check({name, "_busy"}, 71'(busy), 71'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (cp0_wen || flush) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: actual wen=%0b flush=%0b addr=%0d data=%h pc=%h, required no event (cycle %0d)",
                   cp0_wen, flush, cp0_waddr, cp0_wdata, redirect_pc, cyc);
        end else begin
          mon_got = {32'(cyc), cp0_wen, flush, cp0_waddr, flush ? redirect_pc : cp0_wdata};
          check("port_event", mon_got, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0 && exp_q[0][70:39] == 32'(cyc)) begin
        mon_got = {32'(cyc), cp0_wen, flush, cp0_waddr, cp0_wdata};
        check("missing_event", mon_got, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset: outputs all zero while held.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_exc_ack", 71'(exc_ack), 71'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();

    // AdEL in a delay slot: EPC, Cause, BadVAddr, flush.
    exc_code = 5'd4; exc_pc = 32'h8000_0100; exc_bd = 1'b1; exc_badva = 32'h0000_0003;
    exc_req = 1'b1;
    run_until_idle(40);
    repeat (2) tick();

    // Syscall, no delay slot: no BadVAddr write.
    exc_code = 5'd8; exc_pc = 32'h8000_0200; exc_bd = 1'b0; exc_badva = 32'h1234_5678;
    exc_req = 1'b1;
    run_until_idle(40);

    // Simultaneous exception and MTC0: exception wins, MTC0 follows.
    exc_code = 5'd10; exc_pc = 32'h8000_0300; exc_bd = 1'b0; exc_badva = 32'h0;
    exc_req = 1'b1;
    mtc0_addr = 5'd3; mtc0_data = 32'hCAFE_F00D; mtc0_req = 1'b1;
    run_until_idle(40);
    repeat (2) tick();

    // Timer held high: exactly one interrupt until Compare is written.
    int_pc = 32'h8000_0400;
    timer_int = 1'b1;
    repeat (20) tick();
    mtc0_addr = 5'd11; mtc0_data = 32'h0000_1000; mtc0_req = 1'b1;
    run_until_idle(40);
    repeat (8) tick();
    timer_int = 1'b0;
    mtc0_addr = 5'd11; mtc0_data = 32'h0000_2000; mtc0_req = 1'b1;
    run_until_idle(40);

    // Reset while in W_CAUSE: outputs drop at once and no flush follows.
    exc_code = 5'd8; exc_pc = 32'h8000_0500; exc_bd = 1'b0; exc_req = 1'b1;
    exc_taken = 1'b0;
    for (int i = 0; i < 40 && !exc_taken; i++) tick();
    tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    free_at = 0;
    mask = 1'b0;
    exc_req = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if (!exc_req && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: exc_code = 5'd4;
          1: exc_code = 5'd5;
          2: exc_code = 5'd8;
          default: exc_code = 5'($urandom_range(0, 31));
        endcase
        exc_pc = $urandom;
        exc_bd = 1'($urandom_range(0, 1));
        exc_badva = $urandom;
        exc_req = 1'b1;
      end
      if (!mtc0_req && $urandom_range(0, 3) == 0) begin
        mtc0_addr = ($urandom_range(0, 2) == 0) ? 5'd11 : 5'($urandom_range(0, 31));
        mtc0_data = $urandom;
        mtc0_req = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) timer_int = ~timer_int;
      int_pc = $urandom;
      tick();
    end

    timer_int = 1'b0;
    run_until_idle(60);
    mtc0_addr = 5'd11; mtc0_data = 32'h0; mtc0_req = 1'b1;
    run_until_idle(60);
    repeat (4) tick();
    check("queue_drained", 71'(exp_q.size()), 71'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
